// File: rtl/rs_generic.sv
// rs_generic: parametrised reservation station with 2-wide dispatch and issue,
// tagged operand wakeup, age-matrix oldest-first select and synchronous flush.
module rs_generic #(
   parameter int DEPTH     = 16,
   parameter int NUM_WB    = 3,
   parameter int DATA_W    = 16,
   parameter int TAG_W     = 7,
   parameter int ROB_W     = 7,
   parameter int PAYLOAD_W = 32,
   parameter int ENT_W     = PAYLOAD_W + ROB_W + 2 * (1 + TAG_W + DATA_W),
   parameter int ISS_W     = PAYLOAD_W + ROB_W + 2 * DATA_W,
   parameter int CNT_W     = $clog2(DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     stall,
   input  logic                     disp_v1,
   input  logic                     disp_v2,
   input  logic [ENT_W-1:0]         disp_e1,
   input  logic [ENT_W-1:0]         disp_e2,
   input  logic [NUM_WB-1:0]        wb_v,
   input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
   input  logic [NUM_WB*DATA_W-1:0] wb_data,
   output logic                     rs_stall,
   output logic [CNT_W-1:0]         count,
   output logic                     iss_v1,
   output logic                     iss_v2,
   output logic [ISS_W-1:0]         iss_b1,
   output logic [ISS_W-1:0]         iss_b2
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int S1T_LO = DATA_W;
   localparam int S1R    = S1T_LO + TAG_W;
   localparam int S2D_LO = S1R + 1;
   localparam int S2T_LO = S2D_LO + DATA_W;
   localparam int S2R    = S2T_LO + TAG_W;
   localparam int ROB_LO = S2R + 1;
   localparam int PAY_LO = ROB_LO + ROB_W;

   logic [DEPTH-1:0]     valid;
   logic [DEPTH-1:0]     s1_rdy;
   logic [DEPTH-1:0]     s2_rdy;
   logic [TAG_W-1:0]     s1_tag [DEPTH];
   logic [TAG_W-1:0]     s2_tag [DEPTH];
   logic [DATA_W-1:0]    s1_data [DEPTH];
   logic [DATA_W-1:0]    s2_data [DEPTH];
   logic [ROB_W-1:0]     rob_idx [DEPTH];
   logic [PAYLOAD_W-1:0] payload [DEPTH];
   // age[i][j] set means entry j was allocated before entry i
   logic [DEPTH-1:0]     age [DEPTH];
   logic [DEPTH-1:0]     age_nxt [DEPTH];

   logic [DATA_W:0]      wake1 [DEPTH];
   logic [DATA_W:0]      wake2 [DEPTH];
   logic [DATA_W:0]      d1_s1, d1_s2, d2_s1, d2_s2;

   logic [IDX_W-1:0]     free1, free2;
   logic [IDX_W-1:0]     idx1, idx2;
   logic                 disp_ok, acc1, acc2;
   logic [DEPTH-1:0]     alloc;

   logic [DEPTH-1:0]     ready, rest;
   logic [DEPTH-1:0]     sel1_oh, sel2_oh;
   logic [IDX_W-1:0]     sel1, sel2;
   logic                 sel1_v, sel2_v;
   logic [DEPTH-1:0]     valid_nxt;
   logic [CNT_W-1:0]     count_nxt;

   // lowest channel index wins when several channels carry the same tag
   function automatic logic [DATA_W:0] wb_lookup(input logic [TAG_W-1:0] tag);
      logic [DATA_W:0] r;
      r = '0;
      for (int k = NUM_WB - 1; k >= 0; k--) begin
         if (wb_v[k] && wb_tag[k*TAG_W +: TAG_W] == tag)
            r = {1'b1, wb_data[k*DATA_W +: DATA_W]};
      end
      return r;
   endfunction

   function automatic logic [DATA_W:0] src_in(
      input logic              rdy,
      input logic [TAG_W-1:0]  tag,
      input logic [DATA_W-1:0] data
   );
      logic [DATA_W:0] m;
      m = wb_lookup(tag);
      if (rdy)
         m = {1'b1, data};
      else if (!m[DATA_W])
         m = {1'b0, data};
      return m;
   endfunction

   always_comb begin
      d1_s1 = src_in(disp_e1[S1R], disp_e1[S1T_LO +: TAG_W], disp_e1[DATA_W-1:0]);
      d1_s2 = src_in(disp_e1[S2R], disp_e1[S2T_LO +: TAG_W], disp_e1[S2D_LO +: DATA_W]);
      d2_s1 = src_in(disp_e2[S1R], disp_e2[S1T_LO +: TAG_W], disp_e2[DATA_W-1:0]);
      d2_s2 = src_in(disp_e2[S2R], disp_e2[S2T_LO +: TAG_W], disp_e2[S2D_LO +: DATA_W]);
      for (int i = 0; i < DEPTH; i++) begin
         wake1[i] = wb_lookup(s1_tag[i]);
         wake2[i] = wb_lookup(s2_tag[i]);
      end
   end

   always_comb begin
      free1 = '0;
      free2 = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            free2 = free1;
            free1 = IDX_W'(i);
         end
      end
   end

   assign rs_stall = count >= CNT_W'(DEPTH - 1);
   assign disp_ok  = !rs_stall && !stall && !flush;
   assign acc1     = disp_v1 && disp_ok;
   assign acc2     = disp_v2 && disp_ok;
   assign idx1     = free1;
   assign idx2     = disp_v1 ? free2 : free1;

   always_comb begin
      alloc = '0;
      if (acc1)
         alloc[idx1] = 1'b1;
      if (acc2)
         alloc[idx2] = 1'b1;
   end

   assign ready = stall ? '0 : (valid & s1_rdy & s2_rdy);

   always_comb begin
      sel1_oh = '0;
      sel2_oh = '0;
      sel1    = '0;
      sel2    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ready[i] && ((age[i] & ready) == '0))
            sel1_oh[i] = 1'b1;
      end
      rest = ready & ~sel1_oh;
      for (int i = 0; i < DEPTH; i++) begin
         if (rest[i] && ((age[i] & rest) == '0))
            sel2_oh[i] = 1'b1;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (sel1_oh[i])
            sel1 = IDX_W'(i);
         if (sel2_oh[i])
            sel2 = IDX_W'(i);
      end
   end

   assign sel1_v    = |sel1_oh;
   assign sel2_v    = |sel2_oh;
   assign valid_nxt = (valid & ~sel1_oh & ~sel2_oh) | alloc;
   assign count_nxt = count + CNT_W'(acc1) + CNT_W'(acc2)
                    - CNT_W'(sel1_v) - CNT_W'(sel2_v);

   // a new entry is younger than everything: clear its column, load its row
   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         age_nxt[i] = age[i];
      for (int r = 0; r < DEPTH; r++) begin
         if (acc1)
            age_nxt[r][idx1] = 1'b0;
         if (acc2)
            age_nxt[r][idx2] = 1'b0;
      end
      if (acc1)
         age_nxt[idx1] = valid;
      if (acc2)
         age_nxt[idx2] = valid | (acc1 ? (DEPTH'(1) << idx1) : '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid  <= '0;
         s1_rdy <= '0;
         s2_rdy <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            s1_tag[i]  <= '0;
            s2_tag[i]  <= '0;
            s1_data[i] <= '0;
            s2_data[i] <= '0;
            rob_idx[i] <= '0;
            payload[i] <= '0;
            age[i]     <= '0;
         end
         count  <= '0;
         iss_v1 <= 1'b0;
         iss_v2 <= 1'b0;
         iss_b1 <= '0;
         iss_b2 <= '0;
      end else if (flush) begin
         valid  <= '0;
         count  <= '0;
         iss_v1 <= 1'b0;
         iss_v2 <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            age[i] <= age_nxt[i];
            if (valid[i] && !s1_rdy[i] && wake1[i][DATA_W]) begin
               s1_rdy[i]  <= 1'b1;
               s1_data[i] <= wake1[i][DATA_W-1:0];
            end
            if (valid[i] && !s2_rdy[i] && wake2[i][DATA_W]) begin
               s2_rdy[i]  <= 1'b1;
               s2_data[i] <= wake2[i][DATA_W-1:0];
            end
         end
         if (acc1) begin
            s1_rdy[idx1]  <= d1_s1[DATA_W];
            s1_data[idx1] <= d1_s1[DATA_W-1:0];
            s1_tag[idx1]  <= disp_e1[S1T_LO +: TAG_W];
            s2_rdy[idx1]  <= d1_s2[DATA_W];
            s2_data[idx1] <= d1_s2[DATA_W-1:0];
            s2_tag[idx1]  <= disp_e1[S2T_LO +: TAG_W];
            rob_idx[idx1] <= disp_e1[ROB_LO +: ROB_W];
            payload[idx1] <= disp_e1[PAY_LO +: PAYLOAD_W];
         end
         if (acc2) begin
            s1_rdy[idx2]  <= d2_s1[DATA_W];
            s1_data[idx2] <= d2_s1[DATA_W-1:0];
            s1_tag[idx2]  <= disp_e2[S1T_LO +: TAG_W];
            s2_rdy[idx2]  <= d2_s2[DATA_W];
            s2_data[idx2] <= d2_s2[DATA_W-1:0];
            s2_tag[idx2]  <= disp_e2[S2T_LO +: TAG_W];
            rob_idx[idx2] <= disp_e2[ROB_LO +: ROB_W];
            payload[idx2] <= disp_e2[PAY_LO +: PAYLOAD_W];
         end
         valid  <= valid_nxt;
         count  <= count_nxt;
         iss_v1 <= sel1_v;
         iss_v2 <= sel2_v;
         if (sel1_v)
            iss_b1 <= {payload[sel1], rob_idx[sel1], s2_data[sel1], s1_data[sel1]};
         if (sel2_v)
            iss_b2 <= {payload[sel2], rob_idx[sel2], s2_data[sel2], s1_data[sel2]};
      end
   end

endmodule

// File: tb/tb_rs_generic.sv
// tb_rs_generic: directed scenarios plus random traffic for rs_generic,
// checked against an in-order queue model of the station.
module tb_rs_generic;

   localparam int DEPTH     = 16;
   localparam int NUM_WB    = 3;
   localparam int DATA_W    = 16;
   localparam int TAG_W     = 7;
   localparam int ROB_W     = 7;
   localparam int PAYLOAD_W = 32;
   localparam int ENT_W     = PAYLOAD_W + ROB_W + 2 * (1 + TAG_W + DATA_W);
   localparam int ISS_W     = PAYLOAD_W + ROB_W + 2 * DATA_W;
   localparam int CNT_W     = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [PAYLOAD_W-1:0] pay;
      logic [ROB_W-1:0]     rob;
      logic                 r2;
      logic [TAG_W-1:0]     t2;
      logic [DATA_W-1:0]    d2;
      logic                 r1;
      logic [TAG_W-1:0]     t1;
      logic [DATA_W-1:0]    d1;
   } ent_t;

   logic                     clk = 1'b0;
   logic                     reset = 1'b0;
   logic                     flush = 1'b0;
   logic                     stall = 1'b0;
   logic                     disp_v1 = 1'b0;
   logic                     disp_v2 = 1'b0;
   logic [ENT_W-1:0]         disp_e1 = '0;
   logic [ENT_W-1:0]         disp_e2 = '0;
   logic [NUM_WB-1:0]        wb_v = '0;
   logic [NUM_WB*TAG_W-1:0]  wb_tag = '0;
   logic [NUM_WB*DATA_W-1:0] wb_data = '0;
   logic                     rs_stall;
   logic [CNT_W-1:0]         count;
   logic                     iss_v1, iss_v2;
   logic [ISS_W-1:0]         iss_b1, iss_b2;

   rs_generic dut (
      .clk(clk), .reset(reset), .flush(flush), .stall(stall),
      .disp_v1(disp_v1), .disp_v2(disp_v2),
      .disp_e1(disp_e1), .disp_e2(disp_e2),
      .wb_v(wb_v), .wb_tag(wb_tag), .wb_data(wb_data),
      .rs_stall(rs_stall), .count(count),
      .iss_v1(iss_v1), .iss_v2(iss_v2),
      .iss_b1(iss_b1), .iss_b2(iss_b2)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   ent_t q[$];
   logic ev1, ev2;
   logic [ISS_W-1:0] eb1, eb2;

   task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit wb_find(logic [TAG_W-1:0] t, output logic [DATA_W-1:0] d);
      d = '0;
      for (int k = 0; k < NUM_WB; k++) begin
         if (wb_v[k] && wb_tag[k*TAG_W +: TAG_W] == t) begin
            d = wb_data[k*DATA_W +: DATA_W];
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic ent_t wake(ent_t x);
      logic [DATA_W-1:0] d;
      if (!x.r1 && wb_find(x.t1, d)) begin
         x.r1 = 1'b1;
         x.d1 = d;
      end
      if (!x.r2 && wb_find(x.t2, d)) begin
         x.r2 = 1'b1;
         x.d2 = d;
      end
      return x;
   endfunction

   // queue is kept in allocation order, so the first ready entries are oldest
   task automatic model_step();
      bit ok;
      int picks[$];
      ev1 = 1'b0;
      ev2 = 1'b0;
      if (flush) begin
         q.delete();
         return;
      end
      ok = !stall && (q.size() <= DEPTH - 2);
      if (!stall) begin
         foreach (q[i])
            if (q[i].r1 && q[i].r2 && picks.size() < 2)
               picks.push_back(i);
         if (picks.size() > 0) begin
            ev1 = 1'b1;
            eb1 = {q[picks[0]].pay, q[picks[0]].rob, q[picks[0]].d2, q[picks[0]].d1};
         end
         if (picks.size() > 1) begin
            ev2 = 1'b1;
            eb2 = {q[picks[1]].pay, q[picks[1]].rob, q[picks[1]].d2, q[picks[1]].d1};
         end
         for (int j = picks.size() - 1; j >= 0; j--)
            q.delete(picks[j]);
      end
      foreach (q[i])
         q[i] = wake(q[i]);
      if (ok && disp_v1)
         q.push_back(wake(ent_t'(disp_e1)));
      if (ok && disp_v2)
         q.push_back(wake(ent_t'(disp_e2)));
   endtask

   task automatic step();
      chk("rs_stall", rs_stall, q.size() >= DEPTH - 1);
      model_step();
      @(posedge clk);
      #1;
      chk("count", count, q.size());
      chk("iss_v1", iss_v1, ev1);
      chk("iss_v2", iss_v2, ev2);
      if (ev1)
         chk("iss_b1", iss_b1, eb1);
      if (ev2)
         chk("iss_b2", iss_b2, eb2);
   endtask

   task automatic idle();
      disp_v1 = 1'b0;
      disp_v2 = 1'b0;
      wb_v    = '0;
      stall   = 1'b0;
      flush   = 1'b0;
   endtask

   function automatic ent_t mk(int rob, bit r1, int t1, int d1, bit r2, int t2, int d2);
      ent_t x;
      x.pay = 32'hA5A5_0000 | rob;
      x.rob = ROB_W'(rob);
      x.r1  = r1;
      x.t1  = TAG_W'(t1);
      x.d1  = DATA_W'(d1);
      x.r2  = r2;
      x.t2  = TAG_W'(t2);
      x.d2  = DATA_W'(d2);
      return x;
   endfunction

   function automatic ent_t rand_ent();
      ent_t x;
      x.pay = $urandom;
      x.rob = ROB_W'($urandom);
      x.r1  = 1'($urandom_range(1, 0));
      x.t1  = TAG_W'($urandom_range(7, 0));
      x.d1  = DATA_W'($urandom);
      x.r2  = 1'($urandom_range(1, 0));
      x.t2  = TAG_W'($urandom_range(7, 0));
      x.d2  = DATA_W'($urandom);
      return x;
   endfunction

   task automatic bcast(int ch, int tag, int data);
      wb_v[ch] = 1'b1;
      wb_tag[ch*TAG_W +: TAG_W] = TAG_W'(tag);
      wb_data[ch*DATA_W +: DATA_W] = DATA_W'(data);
   endtask

   task automatic rand_inputs();
      disp_v1 = $urandom_range(9, 0) < 7;
      disp_v2 = $urandom_range(9, 0) < 7;
      disp_e1 = rand_ent();
      disp_e2 = rand_ent();
      for (int k = 0; k < NUM_WB; k++) begin
         wb_v[k] = $urandom_range(9, 0) < 3;
         wb_tag[k*TAG_W +: TAG_W] = TAG_W'($urandom_range(7, 0));
         wb_data[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
      stall = $urandom_range(9, 0) == 0;
      flush = $urandom_range(49, 0) == 0;
   endtask

   task automatic async_reset_check(string tag);
      idle();
      #3 reset = 1'b0;
      #1;
      q.delete();
      chk({tag, "_count"}, count, 0);
      chk({tag, "_v1"}, iss_v1, 0);
      chk({tag, "_v2"}, iss_v2, 0);
      chk({tag, "_b1"}, iss_b1, 0);
      chk({tag, "_b2"}, iss_b2, 0);
      chk({tag, "_rs_stall"}, rs_stall, 0);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #12;
      chk("rst_count", count, 0);
      chk("rst_v1", iss_v1, 0);
      chk("rst_v2", iss_v2, 0);
      chk("rst_b1", iss_b1, 0);
      chk("rst_rs_stall", rs_stall, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // single ready instruction, 1-cycle dispatch-to-issue
      idle();
      disp_v1 = 1'b1;
      disp_e1 = mk(2, 1, 0, 16'h0005, 1, 0, 16'h0003);
      step();
      idle();
      chk("t1_count", count, 1);
      step();
      chk("t1_v1", iss_v1, 1);
      chk("t1_opr1", iss_b1[DATA_W-1:0], 16'h0005);
      chk("t1_opr2", iss_b1[2*DATA_W-1:DATA_W], 16'h0003);
      chk("t1_rob", iss_b1[2*DATA_W +: ROB_W], 2);
      chk("t1_count0", count, 0);

      // wait on tag 0x12, broadcast on channel 2 later
      disp_v1 = 1'b1;
      disp_e1 = mk(3, 0, 8'h12, 0, 1, 0, 16'h0007);
      step();
      idle();
      repeat (3) step();
      bcast(2, 8'h12, 16'hBEEF);
      step();
      idle();
      chk("t2_not_same_cycle", iss_v1, 0);
      step();
      chk("t2_v1", iss_v1, 1);
      chk("t2_opr1", iss_b1[DATA_W-1:0], 16'hBEEF);

      // three waiters on one tag: two oldest issue first
      for (int i = 0; i < 3; i++) begin
         disp_v1 = 1'b1;
         disp_e1 = mk(10 + i, 0, 5, 0, 1, 0, 16'h0100 + i);
         step();
      end
      idle();
      bcast(0, 5, 16'h5555);
      step();
      idle();
      step();
      chk("t3_rob1", iss_b1[2*DATA_W +: ROB_W], 10);
      chk("t3_rob2", iss_b2[2*DATA_W +: ROB_W], 11);
      chk("t3_v2", iss_v2, 1);
      step();
      chk("t3_rob_c", iss_b1[2*DATA_W +: ROB_W], 12);
      chk("t3_c_alone", iss_v2, 0);

      // fill to DEPTH-1, dropped dispatch, then one issue frees space
      for (int i = 0; i < 7; i++) begin
         disp_v1 = 1'b1;
         disp_v2 = 1'b1;
         disp_e1 = mk(20 + 2 * i, 0, 8'h7F, 0, 1, 0, 0);
         disp_e2 = mk(21 + 2 * i, 1, 0, 0, 0, 8'h7F, 0);
         step();
      end
      disp_v2 = 1'b0;
      disp_e1 = mk(40, 0, 8'h40, 0, 1, 0, 1);
      step();
      idle();
      chk("t4_full", rs_stall, 1);
      chk("t4_count15", count, 15);
      disp_v1 = 1'b1;
      disp_e1 = mk(41, 1, 0, 1, 1, 0, 1);
      step();
      idle();
      chk("t4_dropped", count, 15);
      bcast(1, 8'h40, 16'h4444);
      step();
      idle();
      step();
      chk("t4_count14", count, 14);
      chk("t4_not_full", rs_stall, 0);
      flush = 1'b1;
      step();
      idle();

      // flush with 8 valid plus a concurrent dispatch
      for (int i = 0; i < 4; i++) begin
         disp_v1 = 1'b1;
         disp_v2 = 1'b1;
         disp_e1 = mk(50 + 2 * i, 0, 8'h7F, 0, 1, 0, 0);
         disp_e2 = mk(51 + 2 * i, 0, 8'h7F, 0, 1, 0, 0);
         step();
      end
      idle();
      chk("t6_count8", count, 8);
      flush   = 1'b1;
      disp_v1 = 1'b1;
      disp_e1 = mk(60, 1, 0, 1, 1, 0, 1);
      step();
      idle();
      chk("t6_count0", count, 0);
      chk("t6_v1", iss_v1, 0);
      chk("t6_v2", iss_v2, 0);
      bcast(0, 8'h7F, 16'h7777);
      step();
      idle();
      repeat (2) step();

      // dispatch bypass from a same-cycle broadcast
      disp_v1 = 1'b1;
      disp_e1 = mk(70, 0, 8'h21, 0, 1, 0, 16'h0009);
      bcast(0, 8'h21, 16'h1234);
      step();
      idle();
      step();
      chk("t5_v1", iss_v1, 1);
      chk("t5_opr1", iss_b1[DATA_W-1:0], 16'h1234);

      for (int c = 0; c < 800; c++) begin
         rand_inputs();
         step();
      end
      async_reset_check("areset");
      for (int c = 0; c < 800; c++) begin
         rand_inputs();
         step();
      end
      idle();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rs_generic.md
# rs_generic

Parametrised reservation station, successor to the fixed-size arithmetic/logical and load/store stations. It sits between the decoder and one execution cluster. It accepts up to two dispatched instructions per cycle and captures operands from NUM_WB tagged writeback channels. It issues up to two ready instructions per cycle in oldest-first order, and supports a real flush.

## Interface
- DEPTH, 16: number of entries (power of 2, ≥4)
- NUM_WB, 3: writeback/broadcast channels
- DATA_W, 16: operand width
- TAG_W, 7: rename tag width
- ROB_W, 7: ROB index width
- PAYLOAD_W, 32: opaque per-instruction control bits (opcode, dests, flags), passed through untouched
- ENT_W (derived) = PAYLOAD_W+ROB_W+2*(1+TAG_W+DATA_W)
- ISS_W (derived) = PAYLOAD_W+ROB_W+2*DATA_W
- CNT_W (derived) = $clog2(DEPTH)+1

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state
- flush  in  1  synchronous squash of all entries
- stall  in  1  external stall: blocks dispatch acceptance and issue; wakeup continues
- disp_v1, disp_v2  in  1  dispatch valid, slot 1 older than slot 2
- disp_e1, disp_e2  in  ENT_W  {payload, rob, s2_rdy, s2_tag, s2_data, s1_rdy, s1_tag, s1_data}, MSB→LSB
- wb_v  in  NUM_WB  per-channel broadcast valid
- wb_tag  in  NUM_WB*TAG_W  channel k at [k*TAG_W +: TAG_W]
- wb_data  in  NUM_WB*DATA_W  channel k at [k*DATA_W +: DATA_W]
- rs_stall  out  1  combinational: free entries < 2
- count  out  CNT_W  registered occupancy
- iss_v1, iss_v2  out  1  registered issue valid, port 1 carries the older instruction
- iss_b1, iss_b2  out  ISS_W  {payload, rob, opr2, opr1}

## Operation
- Entry state: valid, per-source rdy/tag/data, rob, payload, age relation (DEPTH×DEPTH age matrix, or equivalent giving strict allocation order).
- Dispatch is accepted when disp_vN=1, rs_stall=0, stall=0 and flush=0. Slot 1 takes the lowest-index free entry and slot 2 the next free entry. Slot 2 is accepted alone if slot 1 is invalid. Dispatch requests arriving with rs_stall=1 are dropped; the decoder must hold them.
- Dispatch bypass: a source arriving with rdy=0 whose tag matches a valid wb channel in the same cycle is written as ready, taking that channel's data.
- Wakeup: every valid, not-ready source compares against all NUM_WB channels each cycle. On a match it sets rdy and captures the data. If several channels match, the lowest channel index wins.
- Select: among entries with both sources rdy (registered state), the oldest goes to port 1 and the second-oldest to port 2. Selected entries are freed in the same edge.
- Issue outputs are registered. When nothing is selected, iss_vN=0 and iss_bN holds its previous value.
- count updates by +accepted −issued each cycle.
- flush: on the next edge all valid bits, iss_v1 and iss_v2 go to 0 and count goes to 0. Dispatch and wakeup in the flush cycle are discarded. flush has priority over stall.
- stall=1: no select and no dispatch; iss_vN=0 next cycle; wakeup still captured.

## Timing
- Reset (asynchronous, reset=0): all entries invalid, count=0, iss_v1=iss_v2=0, iss_b1=iss_b2=0, age state cleared. rs_stall=0 after reset. Reset asserted mid-operation clears everything immediately.
- An instruction dispatched ready at edge t is eligible for select in cycle t+1. It appears on iss_v at edge t+1, so dispatch-to-issue latency is 1 cycle.
- A broadcast in cycle t makes the consumer eligible in cycle t+1, so it issues at edge t+1. There is no same-cycle wakeup-to-select path.
- An entry is freed on the edge it is selected. It is reusable by dispatch in the following cycle, because rs_stall is computed from registered state.
- Full: with count=DEPTH−1, rs_stall=1, so a single dispatch is also refused. This keeps the decoder interface 2-wide.
- The same tag on two channels in one cycle is legal; the lowest channel index wins.

## Test plan
- Reset then dispatch e1 (both rdy, opr1=0x0005, opr2=0x0003, rob=2) with e2 invalid -> next edge count=1; the following edge iss_v1=1 with iss_b1 opr1=0x0005, opr2=0x0003, rob=2; count=0.
- Dispatch e1 with s1 waiting on tag 0x12, then 3 idle cycles, then wb_v[2]=1, wb_tag=0x12, wb_data=0xBEEF -> issues exactly one edge after the broadcast, opr1=0xBEEF.
- Dispatch A, then B, then C, all waiting on tag 0x05; broadcast 0x05 -> next edge issues A on port 1 and B on port 2; C issues the cycle after.
- Fill to DEPTH−1 -> rs_stall=1; a dispatch offered with rs_stall=1 is dropped and count stays 15. One issue -> rs_stall=0 the next cycle.
- Dispatch a source with rdy=0 and tag 0x21 in the same cycle as wb tag 0x21 / data 0x1234 -> issues the next edge with opr=0x1234.
- With 8 entries valid, pulse flush alongside a dispatch -> next edge count=0, iss_v1=iss_v2=0, and the dispatched entry never issues. Also check an async reset pulse mid-stream gives the same result immediately.
